wb_rr_arb4: RTL and testbench

Four-master round-robin Wishbone arbiter that shares one downstream Wishbone slave path (normally a `wb_stagging` register slice in front of a slave) between four requesters. It selects one master per transaction and muxes that master's request onto the single slave port. It routes the slave's ack/err back to that master only. A programmable watchdog terminates transactions the slave never acknowledges, so a hung slave cannot lock out the other masters.

---
 rtl/wb_rr_arb4.sv | 156 +++++++++++++++
 tb/tb_wb_rr_arb4.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/wb_rr_arb4.sv
// Four-master round-robin Wishbone arbiter with a per-transaction watchdog.
// One grant per transaction; the response is routed back to the granted master only.
module wb_rr_arb4 (
   input  logic         clk_i,
   input  logic         rst_n,
   input  logic [7:0]   cfg_timeout,
   input  logic         cfg_clr_status,
   input  logic [127:0] m_wbd_dat_i,
   input  logic [127:0] m_wbd_adr_i,
   input  logic [15:0]  m_wbd_sel_i,
   input  logic [15:0]  m_wbd_tid_i,
   input  logic [3:0]   m_wbd_we_i,
   input  logic [3:0]   m_wbd_cyc_i,
   input  logic [3:0]   m_wbd_stb_i,
   output logic [31:0]  m_wbd_dat_o,
   output logic [3:0]   m_wbd_ack_o,
   output logic [3:0]   m_wbd_err_o,
   output logic [31:0]  s_wbd_dat_o,
   output logic [31:0]  s_wbd_adr_o,
   output logic [3:0]   s_wbd_sel_o,
   output logic [3:0]   s_wbd_tid_o,
   output logic         s_wbd_we_o,
   output logic         s_wbd_cyc_o,
   output logic         s_wbd_stb_o,
   input  logic [31:0]  s_wbd_dat_i,
   input  logic         s_wbd_ack_i,
   input  logic         s_wbd_err_i,
   output logic         sts_timeout,
   output logic [1:0]   sts_timeout_mid
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t      state_q, state_d;
   logic [1:0]  gnt_q, gnt_d;
   logic [1:0]  last_q, last_d;
   logic [7:0]  wd_q, wd_d;
   logic        sts_q, sts_d;
   logic [1:0]  mid_q, mid_d;

   logic [3:0][31:0] m_dat_v, m_adr_v;
   logic [3:0][3:0]  m_sel_v, m_tid_v;
   logic [3:0]       req;
   logic [1:0]       pick, idx;
   logic             any_req, busy, abort, resp, wd_fire;
   logic [7:0]       tmo_m1;

   assign m_dat_v = m_wbd_dat_i;
   assign m_adr_v = m_wbd_adr_i;
   assign m_sel_v = m_wbd_sel_i;
   assign m_tid_v = m_wbd_tid_i;
   assign req     = m_wbd_cyc_i & m_wbd_stb_i;

   // Scan starting just after the last winner so every requester gets a turn.
   always_comb begin
      pick    = last_q;
      idx     = '0;
      any_req = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         idx = last_q + 2'(i);
         if (!any_req && req[idx]) begin
            pick    = idx;
            any_req = 1'b1;
         end
      end
   end

   assign busy    = (state_q == BUSY);
   assign abort   = busy & ~m_wbd_cyc_i[gnt_q];
   assign resp    = s_wbd_ack_i | s_wbd_err_i;
   assign tmo_m1  = cfg_timeout - 8'd1;
   // A real response in the expiry cycle takes precedence over the watchdog.
   assign wd_fire = busy & ~abort & ~resp & (cfg_timeout != 8'd0) & (wd_q == tmo_m1);

   always_comb begin
      s_wbd_dat_o = '0;
      s_wbd_adr_o = '0;
      s_wbd_sel_o = '0;
      s_wbd_tid_o = '0;
      s_wbd_we_o  = 1'b0;
      s_wbd_cyc_o = 1'b0;
      s_wbd_stb_o = 1'b0;
      m_wbd_ack_o = '0;
      m_wbd_err_o = '0;
      if (busy) begin
         s_wbd_dat_o = m_dat_v[gnt_q];
         s_wbd_adr_o = m_adr_v[gnt_q];
         s_wbd_sel_o = m_sel_v[gnt_q];
         s_wbd_tid_o = m_tid_v[gnt_q];
         s_wbd_we_o  = m_wbd_we_i[gnt_q];
         s_wbd_cyc_o = m_wbd_cyc_i[gnt_q] & ~wd_fire;
         s_wbd_stb_o = m_wbd_stb_i[gnt_q] & ~wd_fire;
         if (!abort) begin
            m_wbd_ack_o[gnt_q] = s_wbd_ack_i;
            m_wbd_err_o[gnt_q] = s_wbd_err_i | wd_fire;
         end
      end
   end

   // Read data is broadcast; held at zero while reset is asserted.
   assign m_wbd_dat_o = rst_n ? s_wbd_dat_i : '0;

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      wd_d    = wd_q;
      sts_d   = sts_q;
      mid_d   = mid_q;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               gnt_d   = pick;
               wd_d    = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            wd_d = (wd_q == 8'hFF) ? wd_q : wd_q + 8'd1;
            if (abort || resp || wd_fire) begin
               state_d = IDLE;
               last_d  = gnt_q;
            end
         end
         default: state_d = IDLE;
      endcase
      if (wd_fire) begin
         sts_d = 1'b1;
         mid_d = gnt_q;
      end else if (cfg_clr_status) begin
         sts_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         gnt_q   <= 2'd0;
         last_q  <= 2'd3;
         wd_q    <= '0;
         sts_q   <= 1'b0;
         mid_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         wd_q    <= wd_d;
         sts_q   <= sts_d;
         mid_q   <= mid_d;
      end
   end

   assign sts_timeout     = sts_q;
   assign sts_timeout_mid = mid_q;

endmodule

// File: tb/tb_wb_rr_arb4.sv
// Vector-table bench for wb_rr_arb4 with a queue of expected outputs.
module tb_wb_rr_arb4;

   logic         clk_i = 1'b0;
   logic         rst_n;
   logic [7:0]   cfg_timeout;
   logic         cfg_clr_status;
   logic [127:0] m_wbd_dat_i, m_wbd_adr_i;
   logic [15:0]  m_wbd_sel_i, m_wbd_tid_i;
   logic [3:0]   m_wbd_we_i, m_wbd_cyc_i, m_wbd_stb_i;
   logic [31:0]  m_wbd_dat_o;
   logic [3:0]   m_wbd_ack_o, m_wbd_err_o;
   logic [31:0]  s_wbd_dat_o, s_wbd_adr_o;
   logic [3:0]   s_wbd_sel_o, s_wbd_tid_o;
   logic         s_wbd_we_o, s_wbd_cyc_o, s_wbd_stb_o;
   logic [31:0]  s_wbd_dat_i;
   logic         s_wbd_ack_i, s_wbd_err_i;
   logic         sts_timeout;
   logic [1:0]   sts_timeout_mid;

   wb_rr_arb4 dut (
      .clk_i(clk_i), .rst_n(rst_n),
      .cfg_timeout(cfg_timeout), .cfg_clr_status(cfg_clr_status),
      .m_wbd_dat_i(m_wbd_dat_i), .m_wbd_adr_i(m_wbd_adr_i),
      .m_wbd_sel_i(m_wbd_sel_i), .m_wbd_tid_i(m_wbd_tid_i),
      .m_wbd_we_i(m_wbd_we_i), .m_wbd_cyc_i(m_wbd_cyc_i), .m_wbd_stb_i(m_wbd_stb_i),
      .m_wbd_dat_o(m_wbd_dat_o), .m_wbd_ack_o(m_wbd_ack_o), .m_wbd_err_o(m_wbd_err_o),
      .s_wbd_dat_o(s_wbd_dat_o), .s_wbd_adr_o(s_wbd_adr_o),
      .s_wbd_sel_o(s_wbd_sel_o), .s_wbd_tid_o(s_wbd_tid_o),
      .s_wbd_we_o(s_wbd_we_o), .s_wbd_cyc_o(s_wbd_cyc_o), .s_wbd_stb_o(s_wbd_stb_o),
      .s_wbd_dat_i(s_wbd_dat_i), .s_wbd_ack_i(s_wbd_ack_i), .s_wbd_err_i(s_wbd_err_i),
      .sts_timeout(sts_timeout), .sts_timeout_mid(sts_timeout_mid)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        rst;
      logic [7:0]  tmo;
      logic        clr;
      logic [3:0]  cyc, stb;
      logic        ack, err;
      logic [31:0] sdat;
      logic        e_scyc, e_sstb;
      logic [31:0] e_sadr;
      logic [3:0]  e_mack, e_merr;
      logic        e_sts;
      logic [1:0]  e_mid;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];
   int   checks = 0;
   int   failures = 0;

   function automatic logic [31:0] adr_of(int k);
      return {4'(k + 1), 28'h0000010};
   endfunction

   function automatic vec_t v(logic rst, logic [7:0] tmo, logic clr, logic [3:0] cyc, logic [3:0] stb,
                              logic ack, logic err, logic [31:0] sdat, logic scyc, logic sstb,
                              logic [31:0] sadr, logic [3:0] mack, logic [3:0] merr,
                              logic sts, logic [1:0] mid);
      vec_t r;
      r.rst = rst; r.tmo = tmo; r.clr = clr; r.cyc = cyc; r.stb = stb;
      r.ack = ack; r.err = err; r.sdat = sdat; r.e_scyc = scyc; r.e_sstb = sstb;
      r.e_sadr = sadr; r.e_mack = mack; r.e_merr = merr; r.e_sts = sts; r.e_mid = mid;
      return r;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      @(posedge clk_i);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      vec_t e;
      rst_n = 1'b0; cfg_timeout = 8'd0; cfg_clr_status = 1'b0;
      m_wbd_we_i = 4'b0; m_wbd_cyc_i = 4'hF; m_wbd_stb_i = 4'hF;
      s_wbd_dat_i = 32'h0; s_wbd_ack_i = 1'b0; s_wbd_err_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         m_wbd_adr_i[32*k +: 32] = adr_of(k);
         m_wbd_dat_i[32*k +: 32] = 32'hD000_0000 | 32'(k);
         m_wbd_sel_i[4*k +: 4]   = 4'hF;
         m_wbd_tid_i[4*k +: 4]   = 4'(k);
      end

      // single request, then error forwarding and an ack while idle
      vecs.push_back(v(1,0,0,4'b0100,4'b0100,0,0,0,            0,0,0,0,0,0,0));
      vecs.push_back(v(0,0,0,4'b0100,4'b0100,0,0,0,            1,1,adr_of(2),0,0,0,0));
      vecs.push_back(v(0,0,0,4'b0100,4'b0100,1,0,32'hA5A5_0001,1,1,adr_of(2),4'b0100,0,0,0));
      vecs.push_back(v(0,0,0,4'b0000,4'b0000,1,0,32'h0000_1234,0,0,0,0,0,0,0));
      vecs.push_back(v(0,0,0,4'b0010,4'b0010,0,0,0,            0,0,0,0,0,0,0));
      vecs.push_back(v(0,0,0,4'b0010,4'b0010,0,1,0,            1,1,adr_of(1),0,4'b0010,0,0));
      vecs.push_back(v(0,0,0,4'b0000,4'b0000,0,0,0,            0,0,0,0,0,0,0));
      // round robin from reset: 0,1,2,3,0 with one idle cycle between grants
      vecs.push_back(v(1,0,0,4'hF,4'hF,0,0,0,0,0,0,0,0,0,0));
      for (int k = 0; k < 5; k++) begin
         vecs.push_back(v(0,0,0,4'hF,4'hF,1,0,0,1,1,adr_of(k % 4),4'(1 << (k % 4)),0,0,0));
         vecs.push_back(v(0,0,0,4'hF,4'hF,0,0,0,0,0,0,0,0,0,0));
      end
      // watchdog, cfg_timeout=4, master 1, then clear
      vecs.push_back(v(1,4,0,4'b0010,4'b0010,0,0,0,0,0,0,0,0,0,0));
      for (int k = 0; k < 3; k++)
         vecs.push_back(v(0,4,0,4'b0010,4'b0010,0,0,0,1,1,adr_of(1),0,0,0,0));
      vecs.push_back(v(0,4,0,4'b0010,4'b0010,0,0,0,0,0,adr_of(1),0,4'b0010,0,0));
      vecs.push_back(v(0,4,0,4'b0000,4'b0000,0,0,0,0,0,0,0,0,1,1));
      vecs.push_back(v(0,4,1,4'b0000,4'b0000,0,0,0,0,0,0,0,0,1,1));
      vecs.push_back(v(0,4,0,4'b0000,4'b0000,0,0,0,0,0,0,0,0,0,1));
      // ack in the expiry cycle, cfg_timeout=3, master 0
      vecs.push_back(v(0,3,0,4'b0001,4'b0001,0,0,0,0,0,0,0,0,0,1));
      for (int k = 0; k < 2; k++)
         vecs.push_back(v(0,3,0,4'b0001,4'b0001,0,0,0,1,1,adr_of(0),0,0,0,1));
      vecs.push_back(v(0,3,0,4'b0001,4'b0001,1,0,0,1,1,adr_of(0),4'b0001,0,0,1));
      vecs.push_back(v(0,3,0,4'b0000,4'b0000,0,0,0,0,0,0,0,0,0,1));
      // cfg_timeout=1 with a clear in the same cycle: timeout wins
      vecs.push_back(v(0,1,0,4'b0100,4'b0100,0,0,0,0,0,0,0,0,0,1));
      vecs.push_back(v(0,1,1,4'b0100,4'b0100,0,0,0,0,0,adr_of(2),0,4'b0100,0,1));
      vecs.push_back(v(0,1,0,4'b0000,4'b0000,0,0,0,0,0,0,0,0,1,2));
      // abort: master 3 drops cyc in 2nd busy cycle, ack there and after is dropped
      vecs.push_back(v(1,0,0,4'b1000,4'b1000,0,0,0,0,0,0,0,0,0,0));
      vecs.push_back(v(0,0,0,4'b1000,4'b1000,0,0,0,1,1,adr_of(3),0,0,0,0));
      vecs.push_back(v(0,0,0,4'b0000,4'b1000,1,0,0,0,1,adr_of(3),0,0,0,0));
      vecs.push_back(v(0,0,0,4'b0000,4'b0000,1,0,0,0,0,0,0,0,0,0));

      // reset state, with every master requesting
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_s_cyc", 32'(s_wbd_cyc_o), 0);
      chk("rst_s_stb", 32'(s_wbd_stb_o), 0);
      chk("rst_s_adr", s_wbd_adr_o, 0);
      chk("rst_m_ack", 32'(m_wbd_ack_o), 0);
      chk("rst_m_err", 32'(m_wbd_err_o), 0);
      chk("rst_sts",   32'({sts_timeout, sts_timeout_mid}), 0);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].rst) pulse_reset();
         cfg_timeout = vecs[i].tmo;   cfg_clr_status = vecs[i].clr;
         m_wbd_cyc_i = vecs[i].cyc;   m_wbd_stb_i = vecs[i].stb;
         s_wbd_ack_i = vecs[i].ack;   s_wbd_err_i = vecs[i].err;
         s_wbd_dat_i = vecs[i].sdat;
         sb.push_back(vecs[i]);
         #3;
         e = sb.pop_front();
         chk($sformatf("v%0d_s_cyc", i), 32'(s_wbd_cyc_o), 32'(e.e_scyc));
         chk($sformatf("v%0d_s_stb", i), 32'(s_wbd_stb_o), 32'(e.e_sstb));
         chk($sformatf("v%0d_s_adr", i), s_wbd_adr_o, e.e_sadr);
         chk($sformatf("v%0d_m_ack", i), 32'(m_wbd_ack_o), 32'(e.e_mack));
         chk($sformatf("v%0d_m_err", i), 32'(m_wbd_err_o), 32'(e.e_merr));
         chk($sformatf("v%0d_m_dat", i), m_wbd_dat_o, e.sdat);
         chk($sformatf("v%0d_sts", i), 32'(sts_timeout), 32'(e.e_sts));
         chk($sformatf("v%0d_mid", i), 32'(sts_timeout_mid), 32'(e.e_mid));
         @(posedge clk_i);
         #1;
      end

      // asynchronous reset in the middle of a transaction
      cfg_timeout = 8'd0; cfg_clr_status = 1'b0;
      s_wbd_ack_i = 1'b0; s_wbd_err_i = 1'b0; s_wbd_dat_i = 32'h0;
      m_wbd_cyc_i = 4'b1000; m_wbd_stb_i = 4'b1000;
      @(posedge clk_i);
      #1;
      chk("arst_pre_stb", 32'(s_wbd_stb_o), 1);
      s_wbd_ack_i = 1'b1; s_wbd_dat_i = 32'hDEAD_BEEF;
      rst_n = 1'b0;
      #1;
      chk("arst_s_cyc", 32'(s_wbd_cyc_o), 0);
      chk("arst_s_stb", 32'(s_wbd_stb_o), 0);
      chk("arst_s_adr", s_wbd_adr_o, 0);
      chk("arst_m_ack", 32'(m_wbd_ack_o), 0);
      chk("arst_m_dat", m_wbd_dat_o, 0);
      @(posedge clk_i);
      #1;
      rst_n = 1'b1; s_wbd_ack_i = 1'b0; s_wbd_dat_i = 32'h0;
      m_wbd_cyc_i = 4'hF; m_wbd_stb_i = 4'hF;
      #2 chk("arst_idle_stb", 32'(s_wbd_stb_o), 0);
      @(posedge clk_i);
      #1;
      chk("arst_regrant_adr", s_wbd_adr_o, adr_of(0));
      chk("arst_regrant_stb", 32'(s_wbd_stb_o), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
